dsp_addsub_pipe: RTL and testbench
==================================

# dsp_addsub_pipe

Parametrised, pipelined add/subtract unit for the sail-core datapath, the successor to the single-cycle 32-bit DSP adder. Operands are split into 16-bit lanes; each pipeline stage resolves one lane and registers its carry into the next, so the critical path is one 16-bit add regardless of width. Valid/ready handshakes on both sides allow back-pressure from the consumer. Status flags (carry, signed overflow, zero) and a sideband tag travel with each result.

## Interface
- WIDTH, 32, operand/result width; multiple of 16, range 16..64.
- TAG_W, 4, sideband tag width; min 1.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 = A+B, 1 = A−B.
- in_tag  in  TAG_W  opaque tag, returned unchanged with the result.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result this cycle.
- out_result  out  WIDTH  sum/difference, modulo 2^WIDTH.
- out_carry  out  1  carry out of the MSB (for sub: 1 = no borrow).
- out_ovf  out  1  two's-complement signed overflow.
- out_zero  out  1  out_result == 0.
- out_tag  out  TAG_W  tag of this result.

## Operation
- N = WIDTH/16 lanes, N pipeline stages. Stage k (1..N) holds: valid bit, tag, op, the finished low lanes 0..k−1, the unprocessed upper A/B lanes, and the carry out of lane k−1.
- Subtract: B is inverted at acceptance and the lane-0 carry-in is 1, so A + ~B + 1. Add: lane-0 carry-in is 0.
- Stage k computes lane k−1 as a 17-bit sum {carry, 16-bit sum} = A_lane + B_lane + carry_in, where carry_in is the registered carry from stage k−1 (the sub/add carry-in for k = 1).
- Flags are computed in stage N from the final lane:
  - out_ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the possibly inverted B.
  - out_zero = all result bits zero, registered with the result.
  - out_carry = the lane N−1 carry out.
- Global advance enable: en = !out_valid || out_ready. All stages shift together when en = 1 and hold when en = 0.
- in_ready = en, combinational from out_valid and out_ready.
- A beat is accepted when in_valid && in_ready. Bubbles (valid = 0) propagate as ordinary beats, so no compaction.
- Data and tag registers may update on bubbles; only the valid bits are significant.

## Timing
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+N−1 (visible in cycle t+N−1). That is 2 cycles for WIDTH=32 and 4 cycles for WIDTH=64, counting the accept edge as cycle 1.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: with out_valid = 1 and out_ready = 0, all outputs and every stage are frozen and in_ready = 0. The output must not change while it is not accepted.
- Simultaneous drain and fill: out_valid && out_ready && in_valid all shift in the same cycle, with no lost beat and no bubble inserted.
- Reset (async assert, released synchronously by the environment): all stage valid bits go to 0, out_valid = 0, and out_result, out_carry, out_ovf, out_zero and out_tag go to 0.
  - in_ready = 1 after reset.
  - Asserting reset mid-flight discards every in-flight beat; no partial result is emitted after release.
- Wrap-around: results are modulo 2^WIDTH with no saturation; overflow is reported only via the flags.

## Test plan
- WIDTH=32, add 0x0000FFFF + 0x00000001, out_ready = 1 → after 2 cycles: out_result = 0x00010000, carry 0, ovf 0, zero 0 (exercises the inter-lane carry).
- WIDTH=32, add 0xFFFFFFFF + 0x00000001 with tag 0xA → result 0x00000000, carry 1, ovf 0, zero 1, out_tag 0xA.
- WIDTH=32, sub 0x80000000 − 0x00000001 → 0x7FFFFFFF, carry 1, ovf 1. Then sub 0x00000000 − 0x00000001 → 0xFFFFFFFF, carry 0, ovf 0.
- WIDTH=32, stream 8 beats back-to-back with out_ready toggling 1,0,0,1,… → results in order with tags intact, none dropped or duplicated. in_ready is low exactly when out_valid && !out_ready, and the outputs are stable during each stall.
- Accept 2 beats, assert rst for 1 cycle mid-flight → out_valid and all outputs are 0 immediately. After release, no stale beat emerges, and a new beat 5 + 7 = 12 completes with normal latency.
- WIDTH=64, add 0x00000000FFFFFFFF + 1 → 0x0000000100000000 after 4 cycles. Add 0x7FFFFFFFFFFFFFFF + 1 → 0x8000000000000000 with ovf 1, carry 0.

Source files
------------

// File: rtl/dsp_addsub_pipe.sv
// Pipelined add/subtract unit: one 16-bit lane resolved per stage, with the carry registered
// between stages. Carry, signed overflow, zero and a sideband tag travel with each result.
module dsp_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int N = WIDTH / 16;

    logic                        en;
    logic [WIDTH-1:0]            b_eff;

    logic [N-1:0]                valid_q;
    logic [N-1:0][TAG_W-1:0]     tag_q;
    logic [N-1:0][WIDTH-1:0]     a_q;
    logic [N-1:0][WIDTH-1:0]     b_q;
    logic [N-1:0][WIDTH-1:0]     res_q;
    logic [N-1:0]                carry_q;
    logic                        ovf_q;
    logic                        zero_q;

    logic [N-1:0][WIDTH-1:0]     src_a;
    logic [N-1:0][WIDTH-1:0]     src_b;
    logic [N-1:0][WIDTH-1:0]     src_res;
    logic [N-1:0]                src_cin;
    logic [N-1:0][16:0]          lane_sum;
    logic [N-1:0][WIDTH-1:0]     next_res;
    logic                        ovf_next;
    logic                        zero_next;

    // The whole pipe moves as one; bubbles shift through like real beats.
    assign en       = !valid_q[N-1] || out_ready;
    assign in_ready = en;
    assign b_eff    = in_sub ? ~in_b : in_b;

    // Stage s adds lane s, fed by the inputs (s = 0) or the previous stage's registers.
    always_comb begin
        src_a    = '0;
        src_b    = '0;
        src_res  = '0;
        src_cin  = '0;
        lane_sum = '0;
        next_res = '0;

        src_a[0]   = in_a;
        src_b[0]   = b_eff;
        src_cin[0] = in_sub;
        for (int s = 1; s < N; s++) begin
            src_a[s]   = a_q[s-1];
            src_b[s]   = b_q[s-1];
            src_res[s] = res_q[s-1];
            src_cin[s] = carry_q[s-1];
        end

        for (int s = 0; s < N; s++) begin
            lane_sum[s] = {1'b0, src_a[s][16*s +: 16]} + {1'b0, src_b[s][16*s +: 16]}
                        + {16'b0, src_cin[s]};
            next_res[s] = src_res[s];
            next_res[s][16*s +: 16] = lane_sum[s][15:0];
        end

        ovf_next  = (src_a[N-1][WIDTH-1] == src_b[N-1][WIDTH-1])
                 && (lane_sum[N-1][15] != src_a[N-1][WIDTH-1]);
        zero_next = (next_res[N-1] == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            tag_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (en) begin
            valid_q[0] <= in_valid;
            tag_q[0]   <= in_tag;
            a_q[0]     <= in_a;
            b_q[0]     <= b_eff;
            for (int s = 1; s < N; s++) begin
                valid_q[s] <= valid_q[s-1];
                tag_q[s]   <= tag_q[s-1];
                a_q[s]     <= a_q[s-1];
                b_q[s]     <= b_q[s-1];
            end
            for (int s = 0; s < N; s++) begin
                res_q[s]   <= next_res[s];
                carry_q[s] <= lane_sum[s][16];
            end
            ovf_q  <= ovf_next;
            zero_q <= zero_next;
        end
    end

    assign out_valid  = valid_q[N-1];
    assign out_result = res_q[N-1];
    assign out_carry  = carry_q[N-1];
    assign out_ovf    = ovf_q;
    assign out_zero   = zero_q;
    assign out_tag    = tag_q[N-1];

endmodule

// File: tb/tb_dsp_addsub_pipe.sv
// Bench for dsp_addsub_pipe: a 32-bit and a 64-bit instance checked against an
// arithmetic reference model and an in-order expected-result queue.
module tb_dsp_addsub_pipe;

    typedef struct {
        logic [63:0] res;
        logic        c;
        logic        o;
        logic        z;
        logic [3:0]  tag;
        int          acc;
        logic        lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        v32, s32, r32, ir32, ov32, c32, o32, z32;
    logic [31:0] a32, b32, res32;
    logic [3:0]  t32, ot32;

    logic        v64, s64, r64, ir64, ov64, c64, o64, z64;
    logic [63:0] a64, b64, res64;
    logic [3:0]  t64, ot64;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        sel   = 1'b0;
    exp_t        q[$];

    logic        stall_prev = 1'b0;
    logic [63:0] held_res;
    logic        held_c, held_o, held_z;
    logic [3:0]  held_tag;

    always #5 clk = ~clk;

    dsp_addsub_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(v32), .in_ready(ir32), .in_a(a32), .in_b(b32), .in_sub(s32), .in_tag(t32),
        .out_valid(ov32), .out_ready(r32), .out_result(res32), .out_carry(c32),
        .out_ovf(o32), .out_zero(z32), .out_tag(ot32)
    );

    dsp_addsub_pipe #(.WIDTH(64), .TAG_W(4)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(v64), .in_ready(ir64), .in_a(a64), .in_b(b64), .in_sub(s64), .in_tag(t64),
        .out_valid(ov64), .out_ready(r64), .out_result(res64), .out_carry(c64),
        .out_ovf(o64), .out_zero(z64), .out_tag(ot64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic, unsigned carry/borrow, signed range test for overflow.
    function automatic exp_t model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                   input logic s, input logic [3:0] t);
        exp_t               e;
        logic [63:0]        mask, a, b;
        logic [64:0]        wide;
        logic signed [127:0] sa, sb, r, maxv, minv;
        mask  = (w == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
        a     = a_in & mask;
        b     = b_in & mask;
        e.res = (s ? a - b : a + b) & mask;
        wide  = {1'b0, a} + {1'b0, b};
        e.c   = s ? (a >= b) : wide[w];
        sa    = (w == 64) ? {{64{a[63]}}, a} : {{96{a[31]}}, a[31:0]};
        sb    = (w == 64) ? {{64{b[63]}}, b} : {{96{b[31]}}, b[31:0]};
        r     = s ? sa - sb : sa + sb;
        maxv  = (128'sd1 <<< (w - 1)) - 128'sd1;
        minv  = -maxv - 128'sd1;
        e.o   = (r > maxv) || (r < minv);
        e.z   = (e.res == 64'd0);
        e.tag = t;
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    // One clock cycle on the selected instance; called just after a falling edge.
    task automatic applyStimulus(input logic v, input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input logic [3:0] t, input logic rdy,
                                 input logic lat, output logic accepted);
        logic        ov, ir, oc, oo, oz;
        logic [63:0] ores;
        logic [3:0]  otag;
        exp_t        e;
        int          n;
        n = sel ? 4 : 2;
        if (sel) begin
            v64 = v; a64 = a; b64 = b; s64 = s; t64 = t; r64 = rdy;
            v32 = 1'b0; r32 = 1'b1;
        end else begin
            v32 = v; a32 = a[31:0]; b32 = b[31:0]; s32 = s; t32 = t; r32 = rdy;
            v64 = 1'b0; r64 = 1'b1;
        end
        #1;
        ov   = sel ? ov64 : ov32;
        ir   = sel ? ir64 : ir32;
        ores = sel ? res64 : {32'b0, res32};
        oc   = sel ? c64 : c32;
        oo   = sel ? o64 : o32;
        oz   = sel ? z64 : z32;
        otag = sel ? ot64 : ot32;

        chk("in_ready", {63'b0, ir}, {63'b0, !ov || rdy});
        if (stall_prev) begin
            chk("stall_valid", {63'b0, ov}, 64'd1);
            chk("stall_result", ores, held_res);
            chk("stall_flags", {61'b0, oc, oo, oz}, {61'b0, held_c, held_o, held_z});
            chk("stall_tag", {60'b0, otag}, {60'b0, held_tag});
        end
        if (ov && rdy) begin
            if (q.size() == 0) begin
                chk("spurious_beat", {63'b0, ov}, 64'd0);
            end else begin
                e = q.pop_front();
                chk("result", ores, e.res);
                chk("carry", {63'b0, oc}, {63'b0, e.c});
                chk("ovf", {63'b0, oo}, {63'b0, e.o});
                chk("zero", {63'b0, oz}, {63'b0, e.z});
                chk("tag", {60'b0, otag}, {60'b0, e.tag});
                if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(n));
            end
        end
        stall_prev = ov && !rdy;
        held_res = ores; held_c = oc; held_o = oo; held_z = oz; held_tag = otag;
        accepted = v && ir;
        if (accepted) begin
            e = model(sel ? 64 : 32, a, b, s, t);
            e.acc = cyc;
            e.lat = lat;
            q.push_back(e);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int cycles);
        logic acc;
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 4'd0, 1'b1, 1'b0, acc);
    endtask

    task automatic checkOutput(input string tag);
        chk(tag, 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic        acc;
        logic [63:0] ra, rb;
        int          sent, guard;
        logic [3:0]  pat;

        rst = 1'b1;
        v32 = 0; a32 = 0; b32 = 0; s32 = 0; t32 = 0; r32 = 1;
        v64 = 0; a64 = 0; b64 = 0; s64 = 0; t64 = 0; r64 = 1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_valid32", {63'b0, ov32}, 64'd0);
        chk("reset_out32", {27'b0, c32, o32, z32, ot32, res32}, 64'd0);
        chk("reset_ready32", {63'b0, ir32}, 64'd1);
        chk("reset_out64", {59'b0, ov64, c64, o64, z64, 1'b0} | res64 | {60'b0, ot64}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] 32-bit directed beats");
        applyStimulus(1'b1, 64'h0000FFFF, 64'h00000001, 1'b0, 4'h1, 1'b1, 1'b1, acc);
        drain(3);
        applyStimulus(1'b1, 64'hFFFFFFFF, 64'h00000001, 1'b0, 4'hA, 1'b1, 1'b1, acc);
        drain(3);
        applyStimulus(1'b1, 64'h80000000, 64'h00000001, 1'b1, 4'h3, 1'b1, 1'b1, acc);
        applyStimulus(1'b1, 64'h00000000, 64'h00000001, 1'b1, 4'h4, 1'b1, 1'b1, acc);
        applyStimulus(1'b1, 64'h7FFFFFFF, 64'h00000001, 1'b0, 4'h5, 1'b1, 1'b1, acc);
        applyStimulus(1'b1, 64'h12345678, 64'h12345678, 1'b1, 4'h6, 1'b1, 1'b1, acc);
        drain(4);
        checkOutput("directed_drain32");

        $display("[TB] 32-bit stream with ready pattern 1,0,0,1");
        pat = 4'b1001;
        sent = 0; guard = 0;
        while (sent < 8 && guard < 100) begin
            applyStimulus(1'b1, 64'($urandom), 64'($urandom), 1'($urandom), 4'(sent + 8),
                          pat[3 - (guard % 4)], 1'b0, acc);
            if (acc) sent++;
            guard++;
        end
        chk("stream_sent", 64'(sent), 64'd8);
        drain(4);
        checkOutput("stream_drain32");

        $display("[TB] 32-bit random traffic");
        for (int i = 0; i < 300; i++) begin
            ra = (i % 16 == 0) ? 64'hFFFFFFFF : 64'($urandom);
            rb = (i % 16 == 0) ? 64'h1 : 64'($urandom);
            applyStimulus(1'($urandom), ra, rb, 1'($urandom), 4'($urandom), 1'($urandom), 1'b0, acc);
        end
        drain(4);
        checkOutput("random_drain32");

        $display("[TB] reset mid-flight");
        applyStimulus(1'b1, 64'd100, 64'd200, 1'b0, 4'h7, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 64'd300, 64'd400, 1'b0, 4'h8, 1'b1, 1'b0, acc);
        v32 = 1'b0;
        rst = 1'b1;
        #1;
        chk("midreset_valid", {63'b0, ov32}, 64'd0);
        chk("midreset_out", {27'b0, c32, o32, z32, ot32, res32}, 64'd0);
        chk("midreset_ready", {63'b0, ir32}, 64'd1);
        q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drain(5);
        applyStimulus(1'b1, 64'd5, 64'd7, 1'b0, 4'h2, 1'b1, 1'b1, acc);
        drain(3);
        checkOutput("post_reset_drain");

        $display("[TB] 64-bit beats");
        sel = 1'b1;
        applyStimulus(1'b1, 64'h00000000FFFFFFFF, 64'd1, 1'b0, 4'h1, 1'b1, 1'b1, acc);
        drain(5);
        applyStimulus(1'b1, 64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b0, 4'h2, 1'b1, 1'b1, acc);
        applyStimulus(1'b1, 64'h0000000000000000, 64'd1, 1'b1, 4'h3, 1'b1, 1'b1, acc);
        applyStimulus(1'b1, 64'h8000000000000000, 64'd1, 1'b1, 4'h4, 1'b1, 1'b1, acc);
        drain(5);
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'($urandom), {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
                          1'($urandom), 4'($urandom), 1'($urandom), 1'b0, acc);
        end
        drain(6);
        checkOutput("random_drain64");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
